// File: rtl/mem_listener_mc.sv
// Memory response listener: pairs incoming refill beats with the oldest pending miss,
// stamps them with address/id/beat index and reports line completion.
module mem_listener_mc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BEATS  = 4,
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_last,
  output logic              received,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [ID_W-1:0]   fifo_id   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BEAT_W-1:0] beat;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              accept;
  logic              beat_last;
  logic              pop;
  logic [ADDR_W-1:0] beat_addr;

  assign fifo_full   = (count == CNT_W'(DEPTH));
  assign fifo_empty  = (count == '0);
  assign req_ready   = !fifo_full;
  assign mem_ready   = !fifo_empty && (!out_valid || out_ready) && !flush;
  assign push        = req_valid && req_ready && !flush;
  assign accept      = mem_valid && mem_ready;
  assign beat_last   = (beat == LAST_BEAT);
  assign pop         = accept && beat_last;
  assign beat_addr   = fifo_addr[rd_ptr] + (ADDR_W'(beat) << OFF_W);
  assign received    = out_valid && out_ready && out_last;
  assign pending_cnt = count;

  // Request payload storage; needs no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_id[wr_ptr]   <= req_id;
    end
  end

  // FIFO pointers, occupancy and beat counter; flush overrides any push/accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept) beat <= beat_last ? '0 : beat + BEAT_W'(1);
    end
  end

  // Output beat register toward the data accessor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_id    <= '0;
      out_beat  <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_addr  <= beat_addr;
      out_data  <= mem_data;
      out_id    <= fifo_id[rd_ptr];
      out_beat  <= beat;
      out_last  <= beat_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The beat counter is authoritative; a disagreeing mem_last is only flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept && (mem_last != beat_last)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_listener_mc.sv
// Directed bench for mem_listener_mc (DATA_W=32, ADDR_W=32, ID_W=2, DEPTH=4, BEATS=4).
module tb_mem_listener_mc;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_id;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        mem_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [1:0]  out_id;
  logic [1:0]  out_beat;
  logic        out_last;
  logic        received;
  logic [2:0]  pending_cnt;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_listener_mc dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_id      (req_id),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .mem_last    (mem_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_beat    (out_beat),
    .out_last    (out_last),
    .received    (received),
    .pending_cnt (pending_cnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [31:0] base, input int i);
    return base ^ (32'hA5A5_0000 | 32'(i));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [1:0] id);
    req_valid = 1'b1;
    req_addr  = addr;
    req_id    = id;
    step();
    req_valid = 1'b0;
  endtask

  // Drives beats 0..n-1 of the head request back-to-back; bad marks a beat carrying a stray mem_last.
  task automatic burst(input logic [31:0] base, input logic [1:0] id, input int bad, input int n);
    for (int i = 0; i < n; i++) begin
      mem_valid = 1'b1;
      mem_data  = mk_data(base, i);
      mem_last  = (i == 3) || (i == bad);
      out_ready = 1'b1;
      #1 check("mem_ready_burst", 64'(mem_ready), 64'd1);
      step();
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_addr", 64'(out_addr), 64'(32'(base + 32'(4 * i))));
      check("out_data", 64'(out_data), 64'(mk_data(base, i)));
      check("out_id", 64'(out_id), 64'(id));
      check("out_beat", 64'(out_beat), 64'(i));
      check("out_last", 64'(out_last), 64'(i == 3));
      check("received", 64'(received), 64'(i == 3));
    end
    mem_valid = 1'b0;
    mem_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_id = '0;
    mem_valid = 1'b0; mem_data = '0; mem_last = 1'b0; out_ready = 1'b1;
    #12 rst = 1'b1;
    step();

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_received", 64'(received), 64'd0);
    check("rst_pending", 64'(pending_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Single 4-beat request.
    push(32'h0000_1000, 2'd2);
    check("single_pending_1", 64'(pending_cnt), 64'd1);
    burst(32'h0000_1000, 2'd2, -1, 4);
    check("single_pending_0", 64'(pending_cnt), 64'd0);
    check("single_err", 64'(err), 64'd0);
    step();
    check("single_drained", 64'(out_valid), 64'd0);

    // Fill the FIFO, attempt an overflow push, then drain in order.
    for (int k = 0; k < 4; k++) push(32'h0000_2000 + 32'(k * 32'h1000), 2'(k));
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_pending", 64'(pending_cnt), 64'd4);
    push(32'h0000_F000, 2'd3);
    check("overflow_ignored", 64'(pending_cnt), 64'd4);
    burst(32'h0000_2000, 2'd0, -1, 4);
    check("pop_req_ready", 64'(req_ready), 64'd1);
    check("pop_pending", 64'(pending_cnt), 64'd3);
    for (int k = 1; k < 4; k++) burst(32'h0000_2000 + 32'(k * 32'h1000), 2'(k), -1, 4);
    check("drain_pending", 64'(pending_cnt), 64'd0);
    step();

    // Backpressure after the first beat.
    push(32'h0000_4000, 2'd1);
    burst(32'h0000_4000, 2'd1, -1, 1);
    out_ready = 1'b0;
    mem_valid = 1'b1;
    mem_data  = mk_data(32'h0000_4000, 1);
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_mem_ready", 64'(mem_ready), 64'd0);
      step();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_beat", 64'(out_beat), 64'd0);
      check("bp_out_data", 64'(out_data), 64'(mk_data(32'h0000_4000, 0)));
      check("bp_out_addr", 64'(out_addr), 64'h4000);
    end
    for (int i = 1; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_data  = mk_data(32'h0000_4000, i);
      mem_last  = (i == 3);
      out_ready = 1'b1;
      step();
      check("bp_rel_beat", 64'(out_beat), 64'(i));
      check("bp_rel_data", 64'(out_data), 64'(mk_data(32'h0000_4000, i)));
    end
    mem_valid = 1'b0;
    mem_last  = 1'b0;
    check("bp_pending", 64'(pending_cnt), 64'd0);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Stray mem_last on beat 1.
    push(32'h0000_9000, 2'd0);
    burst(32'h0000_9000, 2'd0, 1, 4);
    check("err_set", 64'(err), 64'd1);
    step();
    check("err_sticky", 64'(err), 64'd1);

    // Flush mid-burst with a simultaneous push and beat.
    push(32'h0000_5000, 2'd0);
    push(32'h0000_6000, 2'd1);
    burst(32'h0000_5000, 2'd0, -1, 2);
    mem_valid = 1'b1;
    mem_data  = mk_data(32'h0000_5000, 2);
    req_valid = 1'b1;
    req_addr  = 32'h0000_7000;
    req_id    = 2'd2;
    flush     = 1'b1;
    #1 check("flush_mem_ready_now", 64'(mem_ready), 64'd0);
    step();
    flush = 1'b0; req_valid = 1'b0; mem_valid = 1'b0;
    check("flush_pending", 64'(pending_cnt), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_mem_ready", 64'(mem_ready), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    check("flush_err_kept", 64'(err), 64'd1);
    push(32'h0000_8000, 2'd3);
    burst(32'h0000_8000, 2'd3, -1, 4);
    check("post_flush_pending", 64'(pending_cnt), 64'd0);
    step();

    // Address wrap at the top of the address space.
    push(32'hFFFF_FFF8, 2'd1);
    burst(32'hFFFF_FFF8, 2'd1, -1, 4);
    step();

    // Reset mid-burst.
    push(32'h0000_A000, 2'd2);
    burst(32'h0000_A000, 2'd2, 0, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pending", 64'(pending_cnt), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_out_addr", 64'(out_addr), 64'd0);
    step();
    rst = 1'b1;
    step();
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    push(32'h0000_B000, 2'd0);
    burst(32'h0000_B000, 2'd0, -1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
